player_motion: RTL and testbench

- Per-frame player physics for the platformer.
- Sits directly downstream of the stage platform table. It consumes the four bar rectangles of the current stage and produces the player's position and grounded status for the renderer and the shooter logic.
- Each frame tick runs a multi-cycle update: horizontal move, gravity/jump, then a sequential landing check against bars 1..4, then commit.

---
 rtl/game_pkg.sv | 38 +++
 rtl/player_motion_bar_land_check.sv | 36 +++
 rtl/player_motion.sv | 179 +++++++++++++++++
 tb/tb_player_motion.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants for the platformer: screen and player geometry,
// motion tuning, player FSM encoding and the bar-table field helper.
package game_pkg;

  localparam logic [9:0] SCR_W   = 10'd640;
  localparam logic [9:0] SCR_H   = 10'd480;
  localparam logic [9:0] PW      = 10'd16;
  localparam logic [9:0] PH      = 10'd24;
  localparam logic [9:0] SPEED_X = 10'd2;
  localparam logic [9:0] SPAWN_X = 10'd120;
  localparam logic [9:0] SPAWN_Y = 10'd300;
  localparam logic [9:0] X_MAX   = SCR_W - PW;
  localparam logic [9:0] Y_MAX   = SCR_H - PH;

  localparam logic signed [6:0] JUMP_V   = 7'sd10;
  localparam logic signed [6:0] MAX_FALL = 7'sd8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MOVE   = 2'd1;
  localparam logic [1:0] S_COLL   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  // Bars are packed {bar4,bar3,bar2,bar1}, 10 bits each.
  function automatic logic [9:0] bar_field(
    input logic [39:0] v,
    input logic [1:0]  i
  );
    logic [9:0] f;
    unique case (i)
      2'd0:    f = v[9:0];
      2'd1:    f = v[19:10];
      2'd2:    f = v[29:20];
      default: f = v[39:30];
    endcase
    return f;
  endfunction

endpackage

// File: rtl/player_motion_bar_land_check.sv
// One-way platform landing test for a single bar.
// In: bar h_m/h_e/v_m, new x, old y, new y, new vy. Out: hit, land_y.
module bar_land_check
  import game_pkg::*;
(
  input  logic [9:0]         h_m,
  input  logic [9:0]         h_e,
  input  logic [9:0]         v_m,
  input  logic [9:0]         nx,
  input  logic [9:0]         y,
  input  logic signed [10:0] ny,
  input  logic signed [6:0]  nvy,
  output logic               hit,
  output logic signed [10:0] land_y
);

  logic [10:0]        nx_r;
  logic [10:0]        old_feet;
  logic signed [11:0] new_feet;
  logic signed [11:0] top;

  always_comb begin
    nx_r     = {1'b0, nx} + {1'b0, PW};
    old_feet = {1'b0, y} + {1'b0, PH};
    new_feet = $signed({ny[10], ny}) + $signed({2'b00, PH});
    top      = $signed({2'b00, v_m});
    // Feet must cross the bar top on a non-rising frame.
    hit = !nvy[6]
       && (nx_r > {1'b0, h_m})
       && (nx < h_e)
       && (old_feet <= {1'b0, v_m})
       && (new_feet >= top);
    land_y = $signed({1'b0, v_m}) - $signed({1'b0, PH});
  end

endmodule

// File: rtl/player_motion.sv
// Per-frame player physics: move, gravity/jump, 4-bar landing, commit.
// In: clk, reset, frame_tick, stage_load, buttons, bar table. Out: pos, status.
module player_motion
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        stage_load,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  input  logic [39:0] bars_h_m,
  input  logic [39:0] bars_h_e,
  input  logic [39:0] bars_v_m,
  input  logic [39:0] bars_v_e,
  output logic [9:0]  player_x,
  output logic [9:0]  player_y,
  output logic        on_ground,
  output logic        busy,
  output logic        update_done
);

  logic [1:0]         state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [9:0]         x_q, x_d, y_q, y_d, nx_q, nx_d;
  logic signed [6:0]  vy_q, vy_d, nvy_q, nvy_d;
  logic signed [10:0] ny_q, ny_d, cand_q, cand_d;
  logic               og_q, og_d, gnd_q, gnd_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [9:0]         mv_x;
  logic signed [6:0]  mv_vy;
  logic signed [10:0] mv_y;
  logic               hit;
  logic signed [10:0] land_y;
  logic               unused_v_e;

  assign unused_v_e = ^bars_v_e;

  bar_land_check u_land (
    .h_m    (bar_field(bars_h_m, idx_q)),
    .h_e    (bar_field(bars_h_e, idx_q)),
    .v_m    (bar_field(bars_v_m, idx_q)),
    .nx     (nx_q),
    .y      (y_q),
    .ny     (ny_q),
    .nvy    (nvy_q),
    .hit    (hit),
    .land_y (land_y)
  );

  always_comb begin
    mv_x = x_q;
    if (btn_left && !btn_right)
      mv_x = (x_q < SPEED_X) ? 10'd0 : x_q - SPEED_X;
    else if (btn_right && !btn_left)
      mv_x = (x_q > X_MAX - SPEED_X) ? X_MAX : x_q + SPEED_X;

    if (og_q && btn_jump)
      mv_vy = -JUMP_V;
    else if (vy_q >= MAX_FALL)
      mv_vy = MAX_FALL;
    else
      mv_vy = vy_q + 7'sd1;

    mv_y = $signed({1'b0, y_q}) + $signed({{4{mv_vy[6]}}, mv_vy});
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    vy_d    = vy_q;
    og_d    = og_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    nvy_d   = nvy_q;
    cand_d  = cand_q;
    gnd_d   = gnd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Respawn has priority everywhere and aborts any update.
    if (stage_load) begin
      state_d = S_IDLE;
      x_d     = SPAWN_X;
      y_d     = SPAWN_Y;
      vy_d    = '0;
      og_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (frame_tick) begin
            state_d = S_MOVE;
            busy_d  = 1'b1;
          end
        end
        S_MOVE: begin
          nx_d  = mv_x;
          nvy_d = mv_vy;
          ny_d  = mv_y;
          gnd_d = 1'b0;
          if (mv_y[10]) begin
            ny_d  = '0;
            nvy_d = '0;
          end else if (mv_y > $signed({1'b0, Y_MAX})) begin
            ny_d  = $signed({1'b0, Y_MAX});
            gnd_d = 1'b1;
          end
          cand_d  = ny_d;
          idx_d   = 2'd0;
          state_d = S_COLL;
        end
        S_COLL: begin
          if (hit) begin
            if (land_y < cand_q)
              cand_d = land_y;
            gnd_d = 1'b1;
            nvy_d = '0;
          end
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3)
            state_d = S_COMMIT;
        end
        default: begin
          x_d     = nx_q;
          y_d     = cand_q[9:0];
          vy_d    = nvy_q;
          og_d    = gnd_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      x_q     <= SPAWN_X;
      y_q     <= SPAWN_Y;
      vy_q    <= '0;
      og_q    <= 1'b0;
      nx_q    <= '0;
      ny_q    <= '0;
      nvy_q   <= '0;
      cand_q  <= '0;
      gnd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
      og_q    <= og_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      nvy_q   <= nvy_d;
      cand_q  <= cand_d;
      gnd_q   <= gnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign player_x    = x_q;
  assign player_y    = y_q;
  assign on_ground   = og_q;
  assign busy        = busy_q;
  assign update_done = done_q;

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: vector table, corner sequences and
// randomized frames against a behavioural physics model.
module tb_player_motion;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        stage_load;
  logic        btn_left;
  logic        btn_right;
  logic        btn_jump;
  logic [39:0] bars_h_m;
  logic [39:0] bars_h_e;
  logic [39:0] bars_v_m;
  logic [39:0] bars_v_e;
  logic [9:0]  player_x;
  logic [9:0]  player_y;
  logic        on_ground;
  logic        busy;
  logic        update_done;

  int checks = 0;
  int errors = 0;
  int hm[4], he[4], vm[4];
  int m_x, m_y, m_vy, m_og;

  typedef struct {
    logic l, r, j;
    int   ex, ey, eog;
  } vec_t;
  vec_t tbl[9];

  player_motion dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .stage_load  (stage_load),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_jump    (btn_jump),
    .bars_h_m    (bars_h_m),
    .bars_h_e    (bars_h_e),
    .bars_v_m    (bars_v_m),
    .bars_v_e    (bars_v_e),
    .player_x    (player_x),
    .player_y    (player_y),
    .on_ground   (on_ground),
    .busy        (busy),
    .update_done (update_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic load_bars();
    for (int i = 0; i < 4; i++) begin
      bars_h_m[i*10 +: 10] = 10'(hm[i]);
      bars_h_e[i*10 +: 10] = 10'(he[i]);
      bars_v_m[i*10 +: 10] = 10'(vm[i]);
      bars_v_e[i*10 +: 10] = 10'(vm[i] + 8);
    end
  endtask

  task automatic clear_bars();
    for (int i = 0; i < 4; i++) begin
      hm[i] = 0; he[i] = 0; vm[i] = 0;
    end
    load_bars();
  endtask

  task automatic model_spawn();
    m_x = 120; m_y = 300; m_vy = 0; m_og = 0;
  endtask

  // Frame physics from the rules, in plain integers.
  task automatic model_step(input logic l, input logic r, input logic j);
    int nx, ny, nvy, g, cand;
    nx = m_x;
    if (l && !r) nx = (m_x - 2 < 0) ? 0 : m_x - 2;
    if (r && !l) nx = (m_x + 2 > 624) ? 624 : m_x + 2;
    if (m_og != 0 && j) nvy = -10;
    else nvy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
    ny = m_y + nvy;
    g = 0;
    if (ny < 0) begin
      ny = 0; nvy = 0;
    end else if (ny > 456) begin
      ny = 456; g = 1;
    end
    cand = ny;
    for (int i = 0; i < 4; i++) begin
      if (nvy >= 0 && nx + 16 > hm[i] && nx < he[i] &&
          m_y + 24 <= vm[i] && ny + 24 >= vm[i]) begin
        if (vm[i] - 24 < cand) cand = vm[i] - 24;
        g = 1;
        nvy = 0;
      end
    end
    m_x = nx; m_y = cand; m_vy = nvy; m_og = g;
  endtask

  task automatic frame(input logic l, input logic r, input logic j);
    int n;
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j;
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    chk("busy_set", busy, 1);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (update_done) break;
    end
    chk("latency", n, 6);
    model_step(l, r, j);
    chk("x", player_x, m_x);
    chk("y", player_y, m_y);
    chk("on_ground", on_ground, m_og);
    chk("busy_clr", busy, 0);
  endtask

  task automatic respawn();
    @(negedge clk);
    stage_load = 1'b1;
    @(negedge clk);
    stage_load = 1'b0;
    model_spawn();
    chk("respawn_x", player_x, 120);
    chk("respawn_y", player_y, 300);
    chk("respawn_og", on_ground, 0);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int nb, nd;
    nb = 0; nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (busy) nb++;
      if (update_done) nd++;
    end
    chk({tag, "_busy"}, nb, 0);
    chk({tag, "_done"}, nd, 0);
  endtask

  initial begin
    int nd;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 120, 301, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 120, 303, 0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 120, 306, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 120, 310, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 120, 315, 0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 120, 321, 0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 120, 326, 1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 120, 316, 0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 120, 307, 0};

    reset = 1'b1;
    frame_tick = 1'b0; stage_load = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    clear_bars();
    model_spawn();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", player_x, 120);
    chk("rst_y", player_y, 300);
    chk("rst_og", on_ground, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", update_done, 0);
    @(negedge clk);
    reset = 1'b0;

    hm[0] = 100; he[0] = 250; vm[0] = 350;
    load_bars();
    foreach (tbl[i]) begin
      frame(tbl[i].l, tbl[i].r, tbl[i].j);
      chk("tbl_x", player_x, tbl[i].ex);
      chk("tbl_y", player_y, tbl[i].ey);
      chk("tbl_og", on_ground, tbl[i].eog);
    end

    clear_bars();
    respawn();
    repeat (251) frame(1'b0, 1'b1, 1'b0);
    chk("right_622", player_x, 622);
    frame(1'b0, 1'b1, 1'b0);
    chk("right_624", player_x, 624);
    frame(1'b0, 1'b1, 1'b0);
    chk("right_hold", player_x, 624);
    chk("floor_y", player_y, 456);
    chk("floor_og", on_ground, 1);
    frame(1'b1, 1'b1, 1'b0);
    chk("both_x", player_x, 624);
    repeat (312) frame(1'b1, 1'b0, 1'b0);
    chk("left_0", player_x, 0);
    frame(1'b1, 1'b0, 1'b0);
    chk("left_hold", player_x, 0);

    @(negedge clk);
    stage_load = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    stage_load = 1'b0;
    frame_tick = 1'b0;
    model_spawn();
    watch_quiet("sl_tick", 12);
    chk("sl_tick_x", player_x, 120);
    chk("sl_tick_y", player_y, 300);
    chk("sl_tick_og", on_ground, 0);

    repeat (3) frame(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    btn_left = 1'b0; btn_right = 1'b1; btn_jump = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    stage_load = 1'b1;
    @(negedge clk);
    stage_load = 1'b0;
    model_spawn();
    chk("abort_busy", busy, 0);
    watch_quiet("abort", 12);
    chk("abort_x", player_x, 120);
    chk("abort_y", player_y, 300);

    @(negedge clk);
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (update_done) nd++;
    end
    model_step(1'b0, 1'b0, 1'b0);
    chk("retick_done", nd, 1);
    chk("retick_y", player_y, m_y);

    for (int k = 0; k < 300; k++) begin
      if (k % 25 == 0) begin
        for (int i = 0; i < 4; i++) begin
          hm[i] = $urandom_range(0, 600);
          he[i] = hm[i] + $urandom_range(10, 200);
          vm[i] = $urandom_range(60, 470);
        end
        load_bars();
      end
      if ($urandom_range(0, 19) == 0) respawn();
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
